// File: rtl/tetris_key_pkg.sv
// Shared constants and types for the Tetris key input path: key indices,
// default repeat timing and the repeat FSM state encoding.
package tetris_key_pkg;

    localparam int N_KEYS = 5;

    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_ROTATE = 3;
    localparam int KEY_DROP   = 4;

    // Default timing at 100 MHz: 170 ms before the first repeat, 50 ms after.
    localparam int                 DAS_DELAY_DEF   = 17000000;
    localparam int                 ARR_PERIOD_DEF  = 5000000;
    localparam logic [N_KEYS-1:0]  REPEAT_MASK_DEF = 5'b00111;
    localparam int                 CNT_W_DEF       = 25;

    // Width of a key index on the command interface.
    localparam int ID_W = 3;
    typedef logic [ID_W-1:0] key_idx_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_e;

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat engine: follows the most recently pressed repeatable key and
// emits a one-cycle tick after the initial delay and then every repeat period.
module key_repeat_timer #(
    parameter int N_KEYS     = tetris_key_pkg::N_KEYS,
    parameter int DAS_DELAY  = tetris_key_pkg::DAS_DELAY_DEF,
    parameter int ARR_PERIOD = tetris_key_pkg::ARR_PERIOD_DEF,
    parameter int CNT_W      = tetris_key_pkg::CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic [N_KEYS-1:0]            press_i,
    input  logic [N_KEYS-1:0]            key_level_i,
    input  logic [N_KEYS-1:0]            repeat_mask_i,
    output logic                         tick_o,
    output logic [tetris_key_pkg::ID_W-1:0] active_o
);
    import tetris_key_pkg::*;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

    rep_state_e        state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    key_idx_t          active_q, active_d;

    logic [N_KEYS-1:0] rep_press;
    key_idx_t          new_idx;
    logic              held;

    assign rep_press = press_i & repeat_mask_i;
    assign held      = key_level_i[active_q];
    assign active_o  = active_q;

    // Next state: retarget on a new repeatable press, drop on release, else count.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        tick_o   = 1'b0;
        new_idx  = '0;

        // Lowest index wins among simultaneous repeatable presses.
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (rep_press[k]) new_idx = key_idx_t'(k);
        end

        unique case (state_q)
            R_IDLE: begin
                if (|rep_press) begin
                    active_d = new_idx;
                    timer_d  = '0;
                    state_d  = R_DELAY;
                end
            end
            R_DELAY, R_REPEAT: begin
                if (|rep_press) begin
                    active_d = new_idx;
                    timer_d  = '0;
                    state_d  = R_DELAY;
                end else if (!held) begin
                    timer_d = '0;
                    state_d = R_IDLE;
                end else if (timer_q == ((state_q == R_DELAY) ? DAS_LAST : ARR_LAST)) begin
                    tick_o  = 1'b1;
                    timer_d = '0;
                    state_d = R_REPEAT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = R_IDLE;
            end
        endcase

        // Input disabled by the game: park the engine.
        if (!enable_i) begin
            tick_o  = 1'b0;
            timer_d = '0;
            state_d = R_IDLE;
        end
    end

    // State, timer and active-key registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples the same pre-edge values.
        if (rst) begin
            state_q  <= R_IDLE;
            timer_q  <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Key command scheduler: turns debounced key levels into press and
// auto-repeat commands, merges them per key and issues them one at a time
// to the game FSM over valid/ready, lowest key index first.
module key_cmd_scheduler #(
    parameter int                N_KEYS      = tetris_key_pkg::N_KEYS,
    parameter int                DAS_DELAY   = tetris_key_pkg::DAS_DELAY_DEF,
    parameter int                ARR_PERIOD  = tetris_key_pkg::ARR_PERIOD_DEF,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = tetris_key_pkg::REPEAT_MASK_DEF,
    parameter int                CNT_W       = tetris_key_pkg::CNT_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_KEYS-1:0]               key_level,
    input  logic                            enable,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [tetris_key_pkg::ID_W-1:0] cmd_id,
    output logic                            cmd_repeat,
    output logic                            overrun
);
    import tetris_key_pkg::*;

    logic [N_KEYS-1:0] key_prev_q;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] rep_flag_q, rep_flag_d;
    logic              cmd_valid_q, cmd_valid_d;
    key_idx_t          cmd_id_q, cmd_id_d;
    logic              cmd_repeat_q, cmd_repeat_d;
    logic              overrun_q, overrun_d;

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rep_set;
    logic [N_KEYS-1:0] set_ev;
    logic [N_KEYS-1:0] clr;
    logic [N_KEYS-1:0] kept;
    logic              rep_tick;
    key_idx_t          rep_active;
    logic              load;
    key_idx_t          load_idx;

    assign press = key_level & ~key_prev_q;

    key_repeat_timer #(
        .N_KEYS     (N_KEYS),
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD),
        .CNT_W      (CNT_W)
    ) u_repeat (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .press_i       (press),
        .key_level_i   (key_level),
        .repeat_mask_i (REPEAT_MASK),
        .tick_o        (rep_tick),
        .active_o      (rep_active)
    );

    // Merge press/repeat events into per-key pending bits and arbitrate the output.
    always_comb begin
        rep_set      = '0;
        clr          = '0;
        load_idx     = '0;
        cmd_valid_d  = cmd_valid_q;
        cmd_id_d     = cmd_id_q;
        cmd_repeat_d = cmd_repeat_q;

        if (rep_tick) rep_set[rep_active] = 1'b1;
        set_ev = press | rep_set;

        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (pending_q[k]) load_idx = key_idx_t'(k);
        end

        // Output slot is free or being consumed: refill it or go idle.
        load = !cmd_valid_q || cmd_ready;
        if (load) begin
            cmd_valid_d = |pending_q;
            if (|pending_q) begin
                cmd_id_d          = load_idx;
                cmd_repeat_d      = rep_flag_q[load_idx];
                clr[load_idx]     = 1'b1;
            end
        end

        // A slot emptied by this cycle's load is free for a new event without overrun,
        // and a repeat landing there starts a fresh repeat entry.
        kept       = pending_q & ~clr;
        pending_d  = kept | set_ev;
        rep_flag_d = ~press & (rep_flag_q | (rep_set & ~kept));
        overrun_d  = |(set_ev & kept);

        if (!enable) begin
            pending_d   = '0;
            cmd_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // Edge-detect history, pending state and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q   <= '0;
            pending_q    <= '0;
            rep_flag_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= '0;
            cmd_repeat_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            key_prev_q   <= key_level;
            pending_q    <= pending_d;
            rep_flag_q   <= rep_flag_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_id_q     <= cmd_id_d;
            cmd_repeat_q <= cmd_repeat_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_id     = cmd_id_q;
    assign cmd_repeat = cmd_repeat_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler with short repeat timing: a vector table,
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_key_cmd_scheduler;

    localparam int              NK   = 5;
    localparam int              DAS  = 4;
    localparam int              ARR  = 2;
    localparam int              CW   = 4;
    localparam logic [NK-1:0]   MASK = 5'b00111;

    typedef struct {
        logic [NK-1:0] lvl;
        logic          rdy;
        logic          v;
        logic [2:0]    id;
        logic          rep;
        logic          ovr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_level;
    logic          enable;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_id;
    logic          cmd_repeat;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    key_cmd_scheduler #(
        .N_KEYS      (NK),
        .DAS_DELAY   (DAS),
        .ARR_PERIOD  (ARR),
        .REPEAT_MASK (MASK),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_level  (key_level),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_repeat (cmd_repeat),
        .overrun    (overrun)
    );

    // ---------------- reference model ----------------
    // Pending commands are per-key slots; the repeat schedule is computed from
    // the age of the active key's press rather than from a counter.
    logic [NK-1:0] m_prev;
    bit            m_pend   [NK];
    bit            m_is_rep [NK];
    int            m_active;
    int            m_press_cyc;
    int            m_cyc;
    logic          m_valid;
    logic [2:0]    m_id;
    logic          m_rep;
    logic          m_ovr;

    task automatic model_reset();
        m_prev      = '0;
        m_active    = -1;
        m_press_cyc = 0;
        m_cyc       = 0;
        m_valid     = 1'b0;
        m_id        = '0;
        m_rep       = 1'b0;
        m_ovr       = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_pend[k]   = 1'b0;
            m_is_rep[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [NK-1:0] lvl, input logic en, input logic rdy);
        logic [NK-1:0] press;
        logic [NK-1:0] rep_press;
        logic          tick;
        int            age;
        int            pop;
        press     = lvl & ~m_prev;
        rep_press = press & MASK;
        tick      = 1'b0;
        if (m_active >= 0 && rep_press == '0 && lvl[m_active]) begin
            age  = m_cyc - m_press_cyc;
            tick = (age == DAS) || (age > DAS && ((age - DAS) % ARR) == 0);
        end
        if (!en) begin
            for (int k = 0; k < NK; k++) m_pend[k] = 1'b0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_active = -1;
        end else begin
            if (!m_valid || rdy) begin
                pop = -1;
                for (int k = NK - 1; k >= 0; k--) if (m_pend[k]) pop = k;
                m_valid = (pop >= 0);
                if (pop >= 0) begin
                    m_id         = 3'(pop);
                    m_rep        = m_is_rep[pop];
                    m_pend[pop]  = 1'b0;
                end
            end
            m_ovr = 1'b0;
            for (int k = 0; k < NK; k++) begin
                if (press[k] || (tick && k == m_active)) begin
                    if (m_pend[k]) m_ovr = 1'b1;
                    else           m_is_rep[k] = 1'b1;
                    if (press[k])  m_is_rep[k] = 1'b0;
                    m_pend[k] = 1'b1;
                end
            end
            if (rep_press != '0) begin
                for (int k = NK - 1; k >= 0; k--) if (rep_press[k]) m_active = k;
                m_press_cyc = m_cyc;
            end else if (m_active >= 0 && !lvl[m_active]) begin
                m_active = -1;
            end
        end
        m_prev = lvl;
        m_cyc++;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [2:0] id,
                             input logic rep, input logic ovr);
        check({name, ".valid"}, 8'(cmd_valid), 8'(v));
        if (v) begin
            check({name, ".id"},     8'(cmd_id),     8'(id));
            check({name, ".repeat"}, 8'(cmd_repeat), 8'(rep));
        end
        check({name, ".overrun"}, 8'(overrun), 8'(ovr));
    endtask

    task automatic drive(input logic [NK-1:0] l, input logic e, input logic r);
        key_level = l;
        enable    = e;
        cmd_ready = r;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs [0:11];

    initial begin
        logic          exp_v;
        logic [NK-1:0] r_lvl;
        logic          r_en;
        logic          r_rdy;

        // Tap of ROTATE (non-repeating), then RIGHT+DROP together.
        vecs[0]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{5'b01000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{5'b01000, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[3]  = '{5'b01000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{5'b10010, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{5'b10010, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[8]  = '{5'b10010, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
        vecs[9]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

        // Reset state.
        rst = 1'b1;
        drive('0, 1'b1, 1'b1);
        step();
        step();
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check("reset.id", 8'(cmd_id), 8'd0);
        check("reset.repeat", 8'(cmd_repeat), 8'd0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].lvl, 1'b1, vecs[i].rdy);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].id, vecs[i].rep, vecs[i].ovr);
        end

        // Hold LEFT 12 cycles: press at 2, repeats at 6, 8, 10, 12.
        for (int s = 1; s <= 18; s++) begin
            drive((s <= 12) ? 5'b00001 : 5'b00000, 1'b1, 1'b1);
            step();
            exp_v = (s == 2) || (s == 6) || (s == 8) || (s == 10) || (s == 12);
            check_out($sformatf("hold%0d", s), exp_v, 3'd0, (s != 2), 1'b0);
        end

        // Backpressure: press held on the output, repeats merge and overrun.
        for (int s = 1; s <= 12; s++) begin
            drive((s <= 10) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
            step();
            check_out($sformatf("bp%0d", s), (s >= 2), 3'd0, 1'b0, (s == 7) || (s == 9));
        end
        drive('0, 1'b1, 1'b1);
        step();
        check_out("bp_accept", 1'b1, 3'd0, 1'b1, 1'b0);
        step();
        check_out("bp_drain", 1'b0, 3'd0, 1'b0, 1'b0);

        // Retarget: LEFT held, RIGHT pressed at 3 takes over the repeats.
        for (int s = 1; s <= 18; s++) begin
            drive((s >= 15) ? 5'b00000 : ((s >= 3) ? 5'b00011 : 5'b00001), 1'b1, 1'b1);
            step();
            exp_v = (s == 2) || (s == 4) || (s == 8) || (s == 10) || (s == 12) || (s == 14);
            check_out($sformatf("retgt%0d", s), exp_v, (s == 2) ? 3'd0 : 3'd1, (s > 4), 1'b0);
        end

        // Flush: enable low for one cycle with commands pending.
        drive(5'b00111, 1'b1, 1'b0);
        step();
        check_out("flush_a", 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        check_out("flush_b", 1'b1, 3'd0, 1'b0, 1'b0);
        drive(5'b00111, 1'b0, 1'b0);
        step();
        check_out("flush_off", 1'b0, 3'd0, 1'b0, 1'b0);
        for (int s = 0; s < 7; s++) begin
            drive(5'b00111, 1'b1, 1'b1);
            step();
            check_out($sformatf("flush_quiet%0d", s), 1'b0, 3'd0, 1'b0, 1'b0);
        end
        drive('0, 1'b1, 1'b1);
        step();

        // Reset mid-handshake with ROTATE held through reset.
        drive(5'b01000, 1'b1, 1'b0);
        step();
        step();
        check_out("rst_pre", 1'b1, 3'd3, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_out("rst_mid", 1'b0, 3'd0, 1'b0, 1'b0);
        check("rst_mid.id", 8'(cmd_id), 8'd0);
        rst = 1'b0;
        drive(5'b01000, 1'b1, 1'b1);
        step();
        check_out("rst_post_a", 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        check_out("rst_post_b", 1'b1, 3'd3, 1'b0, 1'b0);
        step();
        check_out("rst_post_c", 1'b0, 3'd0, 1'b0, 1'b0);
        drive('0, 1'b1, 1'b1);
        step();

        // Randomized run against the reference model.
        rst = 1'b1;
        drive('0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        model_reset();
        r_lvl = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 9) == 0) r_lvl[k] = ~r_lvl[k];
            end
            r_rdy = ($urandom_range(0, 3) != 0);
            r_en  = ($urandom_range(0, 63) != 0);
            drive(r_lvl, r_en, r_rdy);
            model_step(r_lvl, r_en, r_rdy);
            step();
            check_out($sformatf("rand%0d", c), m_valid, m_id, m_rep, m_ovr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
